reaction_timer_ctrl: RTL and testbench
======================================

REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the clk frequency in Hz used to derive the 1 ms tick.
REQ-002 SHALL have parameter MAX_MS, default 1000, meaning the reaction-time limit in ms; legal range 1..1023.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  debounced, single-cycle pulse that arms a trial.
REQ-006 SHALL have port stop  input  1  debounced, single-cycle reaction-button pulse.
REQ-007 SHALL have port delay  input  1  single-cycle pulse from the upstream random-delay stage marking the end of the random wait.
REQ-008 SHALL have port led_stim  output  1  stimulus LED, high while the reaction is being timed.
REQ-009 SHALL have port time_ms  output  10  measured reaction time in ms, unsigned binary.
REQ-010 SHALL have port result_valid  output  1  high while time_ms holds a completed measurement.
REQ-011 SHALL have port early_err  output  1  high after stop arrived before the stimulus.
REQ-012 SHALL have port timeout  output  1  high after MAX_MS elapsed with no stop.
REQ-013 SHALL have port busy  output  1  high in WAIT_RND and TIMING.

Function
REQ-014 SHALL implement states IDLE, WAIT_RND, TIMING, DONE, EARLY, TIMEOUT.
REQ-015 SHALL move IDLE -> WAIT_RND on start; stop and delay are ignored in IDLE.
REQ-016 SHALL move WAIT_RND -> TIMING on delay, and WAIT_RND -> EARLY on stop; stop and delay in the same cycle SHALL go to EARLY.
REQ-017 SHALL assert led_stim, registered, on the first clock edge after delay is sampled, and clear it on leaving TIMING.
REQ-018 SHALL clear time_ms to 0 and restart the ms prescaler on entry to TIMING, so the first tick occurs exactly CLK_FREQ_HZ/1000 cycles after entry.
REQ-019 SHALL increment time_ms by 1 per ms tick in TIMING.
REQ-020 SHALL move TIMING -> DONE on stop, freezing time_ms; stop coincident with a tick SHALL win, and time_ms SHALL not increment.
REQ-021 SHALL move TIMING -> TIMEOUT on the tick that brings time_ms to MAX_MS; time_ms SHALL saturate at MAX_MS, never wrap.
REQ-022 SHALL hold DONE, EARLY and TIMEOUT until start, which SHALL go directly to WAIT_RND and clear result_valid, early_err and timeout on the same edge.
REQ-023 SHALL ignore start while busy is high.
REQ-024 SHALL decode result_valid only in DONE, early_err only in EARLY, timeout only in TIMEOUT, and busy as described in REQ-013; these are mutually exclusive.
REQ-025 SHALL hold time_ms at 0 in EARLY.
REQ-026 SHALL treat delay pulses outside WAIT_RND as don't-care with no state effect.

Reset
REQ-027 SHALL, while rst_n is low, immediately force state IDLE, led_stim 0, time_ms 0, result_valid 0, early_err 0, timeout 0, busy 0, prescaler 0, independent of clk.
REQ-028 SHALL resume normal operation on the first clk edge after rst_n deasserts; reset mid-trial SHALL abandon the trial with no residual output.

Structure
REQ-029 SHALL place the state enumeration type and the constant for the time_ms width (10) in a shared package, reaction_pkg.
REQ-030 SHALL contain one sub-module, ms_tick_gen, parameterised by CLK_FREQ_HZ, with clk, rst_n, a synchronous clear input and a single-cycle tick output.

Verification
REQ-031 SHALL cover nominal: CLK_FREQ_HZ=10_000 (10 cycles/ms); start, delay 5 cycles later, stop 253 cycles after led_stim rises -> DONE, time_ms=25, result_valid=1, led_stim=0.
REQ-032 SHALL cover early press: start, stop before any delay -> early_err=1, time_ms=0, led_stim never asserted; same-cycle stop+delay -> early_err=1.
REQ-033 SHALL cover timeout: MAX_MS=20, no stop -> timeout=1 exactly 200 cycles after TIMING entry, time_ms=20, no wrap.
REQ-034 SHALL cover tick/stop collision: stop on the cycle of the 7th tick -> time_ms=6.
REQ-035 SHALL cover reset mid-TIMING: drop rst_n asynchronously -> all outputs 0 before the next clk edge; then start works normally.
REQ-036 SHALL cover ignored inputs: start during TIMING and delay in IDLE/DONE -> no state or output change.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer controller.
//   state_t      : controller state encoding
//   TIME_W       : width of the measured reaction time (ms)
//   ms_cycles()  : clock cycles per millisecond, never below 1
package reaction_pkg;

    localparam int TIME_W = 10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RND = 3'd1,
        S_TIMING   = 3'd2,
        S_DONE     = 3'd3,
        S_EARLY    = 3'd4,
        S_TIMEOUT  = 3'd5
    } state_t;

    function automatic int ms_cycles(input int clk_freq_hz);
        return (clk_freq_hz / 1000 > 1) ? (clk_freq_hz / 1000) : 1;
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond tick prescaler.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; holds the prescaler at its reload value
//   tick  : single-cycle pulse once every CLK_FREQ_HZ/1000 cycles
// Implemented as a down-counter with terminal-count compare. While clr is
// high the counter sits at its reload value, so the first tick after clr
// drops is consumed exactly CLK_FREQ_HZ/1000 edges later.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CYC = ms_cycles(CLK_FREQ_HZ);
    localparam int W   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYC - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // Suppressed during clear so a stale terminal count cannot leak out.
    assign tick = !clr && (r_cnt == '0);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer controller.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start        : arms a trial (ignored while busy)
//   stop         : reaction button pulse
//   delay        : end of the upstream random wait
//   led_stim     : stimulus LED, high while timing
//   time_ms      : measured reaction time in ms
//   result_valid : time_ms holds a completed measurement
//   early_err    : stop arrived before the stimulus
//   timeout      : MAX_MS elapsed without stop
//   busy         : trial in progress (WAIT_RND or TIMING)
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | after reset, waiting for start
// WAIT_RND   | armed, waiting for delay (stop here is early)
// TIMING     | LED on, counting ms until stop or MAX_MS
// DONE       | valid measurement held until next start
// EARLY      | stop came before stimulus, held until start
// TIMEOUT    | no stop within MAX_MS, held until start
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int MAX_MS      = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              delay,
    output logic              led_stim,
    output logic [TIME_W-1:0] time_ms,
    output logic              result_valid,
    output logic              early_err,
    output logic              timeout,
    output logic              busy
);

    localparam logic [TIME_W-1:0] MAX_LAST = TIME_W'(MAX_MS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_tick;
    logic              w_clr;
    logic [TIME_W-1:0] r_time_ms;

    // Prescaler runs only in TIMING; held in reload elsewhere so that entry
    // to TIMING restarts the ms period.
    assign w_clr = (r_state != S_TIMING);

    ms_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_ms_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_WAIT_RND;
            end
            S_WAIT_RND: begin
                // stop has priority: a same-cycle stop+delay is an early press
                if (stop)       w_state_nxt = S_EARLY;
                else if (delay) w_state_nxt = S_TIMING;
            end
            S_TIMING: begin
                // stop beats a coincident tick
                if (stop)                               w_state_nxt = S_DONE;
                else if (w_tick && r_time_ms == MAX_LAST) w_state_nxt = S_TIMEOUT;
            end
            S_DONE, S_EARLY, S_TIMEOUT: begin
                if (start) w_state_nxt = S_WAIT_RND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // time_ms is zero throughout WAIT_RND, so it enters TIMING (and EARLY)
    // at zero. It stops advancing at MAX_MS because the FSM leaves TIMING
    // on that same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_ms <= '0;
        end else if (w_state_nxt == S_WAIT_RND || r_state == S_WAIT_RND) begin
            r_time_ms <= '0;
        end else if (r_state == S_TIMING && !stop && w_tick) begin
            r_time_ms <= r_time_ms + TIME_W'(1);
        end
    end

    assign led_stim     = (r_state == S_TIMING);
    assign time_ms      = r_time_ms;
    assign result_valid = (r_state == S_DONE);
    assign early_err    = (r_state == S_EARLY);
    assign timeout      = (r_state == S_TIMEOUT);
    assign busy         = (r_state == S_WAIT_RND) || (r_state == S_TIMING);

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Testbench for reaction_timer_ctrl. Two instances at 10 cycles/ms:
// index 0 with MAX_MS=1000, index 1 with MAX_MS=20.
module tb_reaction_timer_ctrl;

    typedef struct {
        logic [4:0] flags;   // {result_valid, early_err, timeout, busy, led_stim}
        int         tms;
        int         at;      // expected cycle of the event, -1 = any
    } exp_t;

    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_BUSY  = 5'b00010;
    localparam logic [4:0] F_TIME  = 5'b00011;
    localparam logic [4:0] F_DONE  = 5'b10000;
    localparam logic [4:0] F_EARLY = 5'b01000;
    localparam logic [4:0] F_TOUT  = 5'b00100;

    logic       clk;
    logic       rst_s   [2];
    logic       start_s [2];
    logic       stop_s  [2];
    logic       delay_s [2];
    logic       led     [2];
    logic [9:0] tms     [2];
    logic       rv      [2];
    logic       ee      [2];
    logic       to      [2];
    logic       bsy     [2];
    logic [4:0] flg     [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q [2][$];
    logic prev_ev [2];
    logic led_seen [2];

    reaction_timer_ctrl #(.CLK_FREQ_HZ(10_000), .MAX_MS(1000)) dut_a (
        .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]), .stop(stop_s[0]),
        .delay(delay_s[0]), .led_stim(led[0]), .time_ms(tms[0]),
        .result_valid(rv[0]), .early_err(ee[0]), .timeout(to[0]), .busy(bsy[0])
    );

    reaction_timer_ctrl #(.CLK_FREQ_HZ(10_000), .MAX_MS(20)) dut_b (
        .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]), .stop(stop_s[1]),
        .delay(delay_s[1]), .led_stim(led[1]), .time_ms(tms[1]),
        .result_valid(rv[1]), .early_err(ee[1]), .timeout(to[1]), .busy(bsy[1])
    );

    assign flg[0] = {rv[0], ee[0], to[0], bsy[0], led[0]};
    assign flg[1] = {rv[1], ee[1], to[1], bsy[1], led[1]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops an expectation whenever an instance presents a result.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic ev;
            exp_t e;
            ev = rv[i] | ee[i] | to[i];
            if (led[i]) led_seen[i] = 1'b1;
            if (ev && !prev_ev[i]) begin
                if (q[i].size() == 0) begin
                    n_checks++;
                    $display("FAIL dut%0d unexpected_result: flags %b time %0d, expected no result", i, flg[i], tms[i]);
                end else begin
                    e = q[i].pop_front();
                    check($sformatf("dut%0d result_flags", i), int'(flg[i]), int'(e.flags));
                    check($sformatf("dut%0d result_time_ms", i), int'(tms[i]), e.tms);
                    if (e.at >= 0) check($sformatf("dut%0d result_cycle", i), cyc, e.at);
                end
            end
            prev_ev[i] = ev;
        end
    end

    task automatic pulse(input int i, input bit s, input bit p, input bit d);
        @(negedge clk);
        start_s[i] = s; stop_s[i] = p; delay_s[i] = d;
        @(negedge clk);
        start_s[i] = 1'b0; stop_s[i] = 1'b0; delay_s[i] = 1'b0;
    endtask

    // start, then delay sampled 5 edges later; ed = edge of TIMING entry
    task automatic arm(input int i, output int ed);
        pulse(i, 1'b1, 1'b0, 1'b0);
        check($sformatf("dut%0d busy_after_start", i), int'(flg[i]), int'(F_BUSY));
        repeat (3) @(negedge clk);
        pulse(i, 1'b0, 1'b0, 1'b1);
        ed = cyc;
        check($sformatf("dut%0d led_on_entry", i), int'(flg[i]), int'(F_TIME));
        check($sformatf("dut%0d time_on_entry", i), int'(tms[i]), 0);
    endtask

    // stop sampled on edge ed+k
    task automatic stop_at(input int i, input int ed, input int k);
        while (cyc < ed + k - 1) @(negedge clk);
        stop_s[i] = 1'b1;
        @(negedge clk);
        stop_s[i] = 1'b0;
    endtask

    initial begin
        int ed;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0; start_s[i] = 1'b0; stop_s[i] = 1'b0; delay_s[i] = 1'b0;
            prev_ev[i] = 1'b0; led_seen[i] = 1'b0;
        end
        #1;
        check("dut0 reset_flags", int'(flg[0]), int'(F_IDLE));
        check("dut0 reset_time", int'(tms[0]), 0);
        check("dut1 reset_flags", int'(flg[1]), int'(F_IDLE));
        repeat (2) @(negedge clk);
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;

        // delay and stop in IDLE are ignored
        pulse(0, 1'b0, 1'b0, 1'b1);
        check("dut0 idle_delay_ignored", int'(flg[0]), int'(F_IDLE));
        pulse(0, 1'b0, 1'b1, 1'b0);
        check("dut0 idle_stop_ignored", int'(flg[0]), int'(F_IDLE));

        // nominal: stop 253 cycles after LED -> 25 ms
        arm(0, ed);
        q[0].push_back('{F_DONE, 25, ed + 253});
        stop_at(0, ed, 253);
        check("dut0 done_flags", int'(flg[0]), int'(F_DONE));

        // delay in DONE is ignored
        pulse(0, 1'b0, 1'b0, 1'b1);
        check("dut0 done_delay_flags", int'(flg[0]), int'(F_DONE));
        check("dut0 done_delay_time", int'(tms[0]), 25);

        // early press: start clears result on the same edge
        led_seen[0] = 1'b0;
        pulse(0, 1'b1, 1'b0, 1'b0);
        check("dut0 start_clears_result", int'(flg[0]), int'(F_BUSY));
        q[0].push_back('{F_EARLY, 0, -1});
        pulse(0, 1'b0, 1'b1, 1'b0);
        check("dut0 early_led_never_on", int'(led_seen[0]), 0);

        // same-cycle stop and delay is early
        pulse(0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        q[0].push_back('{F_EARLY, 0, -1});
        pulse(0, 1'b0, 1'b1, 1'b1);
        check("dut0 same_cycle_flags", int'(flg[0]), int'(F_EARLY));

        // start during TIMING ignored; stop on the 7th tick -> 6 ms
        arm(0, ed);
        while (cyc < ed + 29) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        check("dut0 start_in_timing_flags", int'(flg[0]), int'(F_TIME));
        check("dut0 start_in_timing_time", int'(tms[0]), 3);
        q[0].push_back('{F_DONE, 6, ed + 70});
        stop_at(0, ed, 70);

        // asynchronous reset mid-TIMING
        arm(0, ed);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 rst_s[0] = 1'b0;
        #1;
        check("dut0 async_reset_flags", int'(flg[0]), int'(F_IDLE));
        check("dut0 async_reset_time", int'(tms[0]), 0);
        @(negedge clk);
        rst_s[0] = 1'b1;
        arm(0, ed);
        q[0].push_back('{F_DONE, 1, ed + 12});
        stop_at(0, ed, 12);

        // timeout at MAX_MS=20: exactly 200 cycles after entry, no wrap
        arm(1, ed);
        q[1].push_back('{F_TOUT, 20, ed + 200});
        repeat (260) @(negedge clk);
        check("dut1 timeout_hold_flags", int'(flg[1]), int'(F_TOUT));
        check("dut1 timeout_no_wrap", int'(tms[1]), 20);
        pulse(1, 1'b1, 1'b0, 1'b0);
        check("dut1 start_clears_timeout", int'(flg[1]), int'(F_BUSY));

        repeat (5) @(negedge clk);
        check("dut0 pending_results", q[0].size(), 0);
        check("dut1 pending_results", q[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
